// File: rtl/single_pkg.sv
// Shared binary32 helpers for the Precision/Single library.
// Holds the field positions, the element type and the ordering and NaN
// predicates used by the max/min reducers.
package single_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    typedef logic [31:0] single_t;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_e;

    // Strict "a greater than b" on raw binary32 bit patterns.
    // A positive sign beats a negative sign, so +0 beats -0.
    // Two positives compare by magnitude bits and two negatives by inverted
    // magnitude. Equal patterns are never greater, which makes the earliest
    // element win a tie. Denormals, infinities and NaNs all fall out of the
    // raw magnitude compare.
    function automatic logic single_gt(input single_t a, input single_t b);
        logic gt;
        if (a[SIGN_BIT] != b[SIGN_BIT]) begin
            gt = ~a[SIGN_BIT];
        end else if (a[SIGN_BIT] == 1'b0) begin
            gt = (a[EXP_MSB:0] > b[EXP_MSB:0]);
        end else begin
            gt = (a[EXP_MSB:0] < b[EXP_MSB:0]);
        end
        return gt;
    endfunction

    // NaN: all-ones exponent and a non-zero mantissa.
    function automatic logic single_is_nan(input single_t x);
        return (&x[EXP_MSB:EXP_LSB]) && (|x[MAN_MSB:0]);
    endfunction

endpackage

// File: rtl/single_max_reduce.sv
// Streaming binary32 max reducer with argmax and element count.
// Accepts one element per cycle while accumulating. After the last element of
// a frame it holds the result until downstream takes it.
// Optional build macro SINGLE_MAX_NAN_EN: NaNs are skipped for the maximum
// (unless the whole frame so far is NaN) and out_nan reports that a NaN was seen.
module single_max_reduce
    import single_pkg::*;
#(
    parameter int IDX_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W-1:0] out_count,
    output logic             out_nan
);

    state_e            state_r, state_s;
    logic              first_r, first_s;
    logic [IDX_W-1:0]  cnt_r, cnt_s;
    single_t           run_max_r, run_max_s;
    logic [IDX_W-1:0]  run_idx_r, run_idx_s;
    logic              in_ready_r, in_ready_s;
    logic              out_valid_r, out_valid_s;
    single_t           out_max_r, out_max_s;
    logic [IDX_W-1:0]  out_idx_r, out_idx_s;
    logic [IDX_W-1:0]  out_count_r, out_count_s;

    logic              in_xfer_s;
    logic              out_xfer_s;
    logic              gt_s;
    logic              upd_s;
    single_t           cand_max_s;
    logic [IDX_W-1:0]  cand_idx_s;

`ifdef SINGLE_MAX_NAN_EN
    logic              elem_nan_s;
    logic              run_is_nan_r, run_is_nan_s;
    logic              nan_seen_r, nan_seen_s;
    logic              out_nan_r, out_nan_s;
`endif

    // Handshakes and the running-max candidate including the current element
    always_comb begin
        in_xfer_s  = in_valid && in_ready_r;
        out_xfer_s = out_valid_r && out_ready;
        gt_s       = single_gt(in_data, run_max_r);
`ifdef SINGLE_MAX_NAN_EN
        // A NaN only ever lands in the running max as the frame's first
        // element; any later non-NaN replaces that held NaN unconditionally.
        elem_nan_s = single_is_nan(in_data);
        if (first_r) begin
            upd_s = 1'b1;
        end else if (elem_nan_s) begin
            upd_s = 1'b0;
        end else if (run_is_nan_r) begin
            upd_s = 1'b1;
        end else begin
            upd_s = gt_s;
        end
`else
        if (first_r) begin
            upd_s = 1'b1;
        end else begin
            upd_s = gt_s;
        end
`endif
        if (upd_s) begin
            cand_max_s = in_data;
            cand_idx_s = cnt_r;
        end else begin
            cand_max_s = run_max_r;
            cand_idx_s = run_idx_r;
        end
    end

    // Next-state and next-register values for the ACCUM/HOLD machine
    always_comb begin
        state_s     = state_r;
        first_s     = first_r;
        cnt_s       = cnt_r;
        run_max_s   = run_max_r;
        run_idx_s   = run_idx_r;
        in_ready_s  = in_ready_r;
        out_valid_s = out_valid_r;
        out_max_s   = out_max_r;
        out_idx_s   = out_idx_r;
        out_count_s = out_count_r;
`ifdef SINGLE_MAX_NAN_EN
        run_is_nan_s = run_is_nan_r;
        nan_seen_s   = nan_seen_r;
        out_nan_s    = out_nan_r;
`endif
        case (state_r)
            ACCUM: begin
                if (in_xfer_s) begin
                    run_max_s = cand_max_s;
                    run_idx_s = cand_idx_s;
                    first_s   = 1'b0;
                    cnt_s     = cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
`ifdef SINGLE_MAX_NAN_EN
                    run_is_nan_s = upd_s ? elem_nan_s : run_is_nan_r;
                    nan_seen_s   = nan_seen_r | elem_nan_s;
`endif
                    if (in_last) begin
                        state_s     = HOLD;
                        in_ready_s  = 1'b0;
                        out_valid_s = 1'b1;
                        out_max_s   = cand_max_s;
                        out_idx_s   = cand_idx_s;
                        out_count_s = cnt_r + {{(IDX_W-1){1'b0}}, 1'b1};
`ifdef SINGLE_MAX_NAN_EN
                        out_nan_s   = nan_seen_r | elem_nan_s;
`endif
                    end else begin
                        state_s = ACCUM;
                    end
                end else begin
                    state_s = ACCUM;
                end
            end
            HOLD: begin
                // No bypass: in_ready stays low on the release cycle.
                if (out_xfer_s) begin
                    state_s     = ACCUM;
                    in_ready_s  = 1'b1;
                    out_valid_s = 1'b0;
                    cnt_s       = {IDX_W{1'b0}};
                    first_s     = 1'b1;
`ifdef SINGLE_MAX_NAN_EN
                    run_is_nan_s = 1'b0;
                    nan_seen_s   = 1'b0;
                    out_nan_s    = 1'b0;
`endif
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s     = ACCUM;
                in_ready_s  = 1'b1;
                out_valid_s = 1'b0;
                cnt_s       = {IDX_W{1'b0}};
                first_s     = 1'b1;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r     <= ACCUM;
            first_r     <= 1'b1;
            cnt_r       <= {IDX_W{1'b0}};
            run_max_r   <= 32'h0000_0000;
            run_idx_r   <= {IDX_W{1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_max_r   <= 32'h0000_0000;
            out_idx_r   <= {IDX_W{1'b0}};
            out_count_r <= {IDX_W{1'b0}};
`ifdef SINGLE_MAX_NAN_EN
            run_is_nan_r <= 1'b0;
            nan_seen_r   <= 1'b0;
            out_nan_r    <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            first_r     <= first_s;
            cnt_r       <= cnt_s;
            run_max_r   <= run_max_s;
            run_idx_r   <= run_idx_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            out_max_r   <= out_max_s;
            out_idx_r   <= out_idx_s;
            out_count_r <= out_count_s;
`ifdef SINGLE_MAX_NAN_EN
            run_is_nan_r <= run_is_nan_s;
            nan_seen_r   <= nan_seen_s;
            out_nan_r    <= out_nan_s;
`endif
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_max   = out_max_r;
    assign out_idx   = out_idx_r;
    assign out_count = out_count_r;
`ifdef SINGLE_MAX_NAN_EN
    assign out_nan   = out_nan_r;
`else
    assign out_nan   = 1'b0;
`endif

endmodule
